axil_arbiter_2x1: RTL and testbench



---
 rtl/axil_arb_pkg.sv | 23 ++
 rtl/axil_arbiter_2x1_rr_arb2.sv | 31 +++
 rtl/axil_arbiter_2x1.sv | 209 ++++++++++++++++++++
 tb/tb_axil_arbiter_2x1.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_arb_pkg.sv
// Shared definitions for the two-master AXI4-Lite arbiter.
//   - FSM state encodings for the write and read paths
//   - AXI OKAY response code
//   - width of a master index (two masters -> one bit)
package axil_arb_pkg;

  localparam int IDX_W = 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_RESP = 2'd2
  } r_state_t;

endpackage

// File: rtl/axil_arbiter_2x1_rr_arb2.sv
// Two-way grant selection, purely combinational.
// Ports:
//   req         in   pending requests, bit i = master i
//   last        in   master granted last time (round-robin build only)
//   grant_valid out  at least one request is pending
//   grant_idx   out  master to grant this cycle
// Build option: AXIL_ARB_FIXED_PRIO_EN makes master 0 always win a tie and
// removes the last-grant input entirely.
module axil_rr_arb2
  import axil_arb_pkg::*;
(
  input  logic [1:0]       req,
`ifndef AXIL_ARB_FIXED_PRIO_EN
  input  logic [IDX_W-1:0] last,
`endif
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  always_comb begin
    grant_valid = |req;
`ifdef AXIL_ARB_FIXED_PRIO_EN
    grant_idx   = req[0] ? 1'b0 : 1'b1;
`else
    // On a tie the master that was not served last time wins.
    if (req[0] && req[1]) grant_idx = ~last;
    else                  grant_idx = req[0] ? 1'b0 : 1'b1;
`endif
  end

endmodule

// File: rtl/axil_arbiter_2x1.sv
// Two-master to one-slave AXI4-Lite arbiter. Read and write paths are
// arbitrated independently, each with one transaction in flight; payload
// comes from the granted master and responses go back to that master only.
// Ports (master-side buses packed, master 0 in the LSBs):
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_axil_aw*/w*/b*           write channels from/to masters 0 and 1
//   s_axil_ar*/r*              read channels from/to masters 0 and 1
//   m_axil_aw*/w*/b*/ar*/r*    single AXI4-Lite port toward the slave
// Build option: AXIL_ARB_FIXED_PRIO_EN selects fixed priority (master 0
// wins) instead of round-robin; the last-grant registers then disappear.
module axil_arbiter_2x1
  import axil_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH/8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2*ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [5:0]              s_axil_awprot,
  input  logic [1:0]              s_axil_awvalid,
  output logic [1:0]              s_axil_awready,
  input  logic [2*DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [2*STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic [1:0]              s_axil_wvalid,
  output logic [1:0]              s_axil_wready,
  output logic [3:0]              s_axil_bresp,
  output logic [1:0]              s_axil_bvalid,
  input  logic [1:0]              s_axil_bready,
  input  logic [2*ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [5:0]              s_axil_arprot,
  input  logic [1:0]              s_axil_arvalid,
  output logic [1:0]              s_axil_arready,
  output logic [2*DATA_WIDTH-1:0] s_axil_rdata,
  output logic [3:0]              s_axil_rresp,
  output logic [1:0]              s_axil_rvalid,
  input  logic [1:0]              s_axil_rready,
  output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
  output logic [2:0]              m_axil_awprot,
  output logic                    m_axil_awvalid,
  input  logic                    m_axil_awready,
  output logic [DATA_WIDTH-1:0]   m_axil_wdata,
  output logic [STRB_WIDTH-1:0]   m_axil_wstrb,
  output logic                    m_axil_wvalid,
  input  logic                    m_axil_wready,
  input  logic [1:0]              m_axil_bresp,
  input  logic                    m_axil_bvalid,
  output logic                    m_axil_bready,
  output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
  output logic [2:0]              m_axil_arprot,
  output logic                    m_axil_arvalid,
  input  logic                    m_axil_arready,
  input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
  input  logic [1:0]              m_axil_rresp,
  input  logic                    m_axil_rvalid,
  output logic                    m_axil_rready
);

  w_state_t         w_state, w_next;
  r_state_t         r_state, r_next;
  logic [IDX_W-1:0] w_gnt, r_gnt;
  logic             aw_done, w_done;
  logic             w_gv, r_gv;
  logic [IDX_W-1:0] w_gi, r_gi;
  logic             aw_hs, w_hs, b_hs, ar_hs, r_hs;

  // The slave takes AW and W together, so a write needs both valids.
  logic [1:0] w_req;
  assign w_req = s_axil_awvalid & s_axil_wvalid;

`ifdef AXIL_ARB_FIXED_PRIO_EN
  axil_rr_arb2 u_w_arb (.req(w_req), .grant_valid(w_gv), .grant_idx(w_gi));
  axil_rr_arb2 u_r_arb (.req(s_axil_arvalid), .grant_valid(r_gv), .grant_idx(r_gi));
`else
  logic [IDX_W-1:0] last_w, last_r;
  axil_rr_arb2 u_w_arb (.req(w_req), .last(last_w), .grant_valid(w_gv), .grant_idx(w_gi));
  axil_rr_arb2 u_r_arb (.req(s_axil_arvalid), .last(last_r), .grant_valid(r_gv), .grant_idx(r_gi));

  // Reset value 1 lets master 0 win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_w <= 1'b1;
      last_r <= 1'b1;
    end else begin
      if (b_hs) last_w <= w_gnt;
      if (r_hs) last_r <= r_gnt;
    end
  end
`endif

  // Granted-master payload, selected once and reused below.
  logic [ADDR_WIDTH-1:0] g_awaddr, g_araddr;
  logic [2:0]            g_awprot, g_arprot;
  logic [DATA_WIDTH-1:0] g_wdata;
  logic [STRB_WIDTH-1:0] g_wstrb;
  assign g_awaddr = w_gnt ? s_axil_awaddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : s_axil_awaddr[ADDR_WIDTH-1:0];
  assign g_awprot = w_gnt ? s_axil_awprot[5:3] : s_axil_awprot[2:0];
  assign g_wdata  = w_gnt ? s_axil_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : s_axil_wdata[DATA_WIDTH-1:0];
  assign g_wstrb  = w_gnt ? s_axil_wstrb[2*STRB_WIDTH-1:STRB_WIDTH] : s_axil_wstrb[STRB_WIDTH-1:0];
  assign g_araddr = r_gnt ? s_axil_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : s_axil_araddr[ADDR_WIDTH-1:0];
  assign g_arprot = r_gnt ? s_axil_arprot[5:3] : s_axil_arprot[2:0];

  // Handshakes derived from state and inputs only, so the output logic
  // below has no combinational path back into itself.
  assign aw_hs = (w_state == W_ADDR) && !aw_done && s_axil_awvalid[w_gnt] && m_axil_awready;
  assign w_hs  = (w_state == W_ADDR) && !w_done  && s_axil_wvalid[w_gnt]  && m_axil_wready;
  assign b_hs  = (w_state == W_RESP) && m_axil_bvalid && s_axil_bready[w_gnt];
  assign ar_hs = (r_state == R_ADDR) && s_axil_arvalid[r_gnt] && m_axil_arready;
  assign r_hs  = (r_state == R_RESP) && m_axil_rvalid && s_axil_rready[r_gnt];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      w_gnt   <= '0;
      r_gnt   <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      if (w_state == W_IDLE && w_gv) begin
        w_gnt   <= w_gi;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (r_state == R_IDLE && r_gv) r_gnt <= r_gi;
    end
  end

  // Write path: next state and channel routing.
  always_comb begin
    w_next         = w_state;
    m_axil_awaddr  = '0;
    m_axil_awprot  = '0;
    m_axil_awvalid = 1'b0;
    m_axil_wdata   = '0;
    m_axil_wstrb   = '0;
    m_axil_wvalid  = 1'b0;
    m_axil_bready  = 1'b0;
    s_axil_awready = '0;
    s_axil_wready  = '0;
    s_axil_bvalid  = '0;
    s_axil_bresp   = {RESP_OKAY, RESP_OKAY};
    case (w_state)
      W_IDLE: if (w_gv) w_next = W_ADDR;
      W_ADDR: begin
        m_axil_awaddr         = g_awaddr;
        m_axil_awprot         = g_awprot;
        m_axil_awvalid        = s_axil_awvalid[w_gnt] && !aw_done;
        m_axil_wdata          = g_wdata;
        m_axil_wstrb          = g_wstrb;
        m_axil_wvalid         = s_axil_wvalid[w_gnt] && !w_done;
        s_axil_awready[w_gnt] = m_axil_awready && !aw_done;
        s_axil_wready[w_gnt]  = m_axil_wready && !w_done;
        if ((aw_done || aw_hs) && (w_done || w_hs)) w_next = W_RESP;
      end
      W_RESP: begin
        s_axil_bvalid[w_gnt] = m_axil_bvalid;
        m_axil_bready        = s_axil_bready[w_gnt];
        if (w_gnt) s_axil_bresp[3:2] = m_axil_bresp;
        else       s_axil_bresp[1:0] = m_axil_bresp;
        if (b_hs) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Read path: next state and channel routing.
  always_comb begin
    r_next         = r_state;
    m_axil_araddr  = '0;
    m_axil_arprot  = '0;
    m_axil_arvalid = 1'b0;
    m_axil_rready  = 1'b0;
    s_axil_arready = '0;
    s_axil_rvalid  = '0;
    s_axil_rdata   = '0;
    s_axil_rresp   = {RESP_OKAY, RESP_OKAY};
    case (r_state)
      R_IDLE: if (r_gv) r_next = R_ADDR;
      R_ADDR: begin
        m_axil_araddr         = g_araddr;
        m_axil_arprot         = g_arprot;
        m_axil_arvalid        = s_axil_arvalid[r_gnt];
        s_axil_arready[r_gnt] = m_axil_arready;
        if (ar_hs) r_next = R_RESP;
      end
      R_RESP: begin
        s_axil_rvalid[r_gnt] = m_axil_rvalid;
        m_axil_rready        = s_axil_rready[r_gnt];
        if (r_gnt) begin
          s_axil_rdata[2*DATA_WIDTH-1:DATA_WIDTH] = m_axil_rdata;
          s_axil_rresp[3:2]                       = m_axil_rresp;
        end else begin
          s_axil_rdata[DATA_WIDTH-1:0] = m_axil_rdata;
          s_axil_rresp[1:0]            = m_axil_rresp;
        end
        if (r_hs) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axil_arbiter_2x1.sv
// Bench for axil_arbiter_2x1: two master drivers, a RAM-like slave with
// programmable ready delays, handshake monitors, and a word-level memory
// model plus grant-order expectations derived from the arbitration rule.
module tb_axil_arbiter_2x1;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic fail(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    bad++;
    $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Master-side drive state, one entry per master.
  logic [AW-1:0] awaddr_d[2], araddr_d[2];
  logic [DW-1:0] wdata_d[2];
  logic [SW-1:0] wstrb_d[2];
  logic          awvalid_d[2], wvalid_d[2], bready_d[2], arvalid_d[2], rready_d[2];

  logic [2*AW-1:0] s_axil_awaddr, s_axil_araddr;
  logic [5:0]      s_axil_awprot, s_axil_arprot;
  logic [1:0]      s_axil_awvalid, s_axil_wvalid, s_axil_bready, s_axil_arvalid, s_axil_rready;
  logic [2*DW-1:0] s_axil_wdata;
  logic [2*SW-1:0] s_axil_wstrb;
  logic [1:0]      s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready, s_axil_rvalid;
  logic [3:0]      s_axil_bresp, s_axil_rresp;
  logic [2*DW-1:0] s_axil_rdata;

  assign s_axil_awaddr  = {awaddr_d[1], awaddr_d[0]};
  assign s_axil_araddr  = {araddr_d[1], araddr_d[0]};
  assign s_axil_awprot  = 6'b010_001;
  assign s_axil_arprot  = 6'b010_001;
  assign s_axil_awvalid = {awvalid_d[1], awvalid_d[0]};
  assign s_axil_wvalid  = {wvalid_d[1], wvalid_d[0]};
  assign s_axil_bready  = {bready_d[1], bready_d[0]};
  assign s_axil_arvalid = {arvalid_d[1], arvalid_d[0]};
  assign s_axil_rready  = {rready_d[1], rready_d[0]};
  assign s_axil_wdata   = {wdata_d[1], wdata_d[0]};
  assign s_axil_wstrb   = {wstrb_d[1], wstrb_d[0]};

  logic [AW-1:0] m_axil_awaddr, m_axil_araddr;
  logic [2:0]    m_axil_awprot, m_axil_arprot;
  logic          m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready;
  logic [DW-1:0] m_axil_wdata;
  logic [SW-1:0] m_axil_wstrb;
  logic          m_axil_awready, m_axil_wready, m_axil_bvalid, m_axil_arready, m_axil_rvalid;
  logic [1:0]    m_axil_bresp, m_axil_rresp;
  logic [DW-1:0] m_axil_rdata;

  axil_arbiter_2x1 dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  wire [14:0] ctl_vec = {s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready,
                         s_axil_rvalid, m_axil_awvalid, m_axil_wvalid, m_axil_bready,
                         m_axil_arvalid, m_axil_rready};

  // RAM slave with independent AW/W/AR ready delays.
  int aw_dly = 0, w_dly = 0, ar_dly = 0;
  int aw_cnt, w_cnt, ar_cnt;
  logic have_aw, have_w;
  logic [AW-1:0] aw_lat;
  logic [DW-1:0] w_lat;
  logic [SW-1:0] s_lat;
  logic [DW-1:0] mem [0:255];
  assign m_axil_bresp = 2'b00;
  assign m_axil_rresp = 2'b00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axil_awready <= 1'b0; m_axil_wready <= 1'b0; m_axil_bvalid <= 1'b0;
      m_axil_arready <= 1'b0; m_axil_rvalid <= 1'b0;
      have_aw <= 1'b0; have_w <= 1'b0; aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
    end else begin
      if (m_axil_awready && m_axil_awvalid) begin
        m_axil_awready <= 1'b0; have_aw <= 1'b1; aw_lat <= m_axil_awaddr; aw_cnt <= 0;
      end else if (m_axil_awvalid && !have_aw && !m_axil_awready) begin
        if (aw_cnt >= aw_dly) m_axil_awready <= 1'b1; else aw_cnt <= aw_cnt + 1;
      end
      if (m_axil_wready && m_axil_wvalid) begin
        m_axil_wready <= 1'b0; have_w <= 1'b1; w_lat <= m_axil_wdata; s_lat <= m_axil_wstrb; w_cnt <= 0;
      end else if (m_axil_wvalid && !have_w && !m_axil_wready) begin
        if (w_cnt >= w_dly) m_axil_wready <= 1'b1; else w_cnt <= w_cnt + 1;
      end
      if (m_axil_bvalid && m_axil_bready) m_axil_bvalid <= 1'b0;
      else if (have_aw && have_w && !m_axil_bvalid) begin
        for (int b = 0; b < SW; b++)
          if (s_lat[b]) mem[aw_lat[9:2]][8*b +: 8] <= w_lat[8*b +: 8];
        m_axil_bvalid <= 1'b1; have_aw <= 1'b0; have_w <= 1'b0;
      end
      if (m_axil_rvalid && m_axil_rready) m_axil_rvalid <= 1'b0;
      if (m_axil_arready && m_axil_arvalid) begin
        m_axil_arready <= 1'b0; m_axil_rvalid <= 1'b1; m_axil_rdata <= mem[m_axil_araddr[9:2]]; ar_cnt <= 0;
      end else if (m_axil_arvalid && !m_axil_rvalid && !m_axil_arready) begin
        if (ar_cnt >= ar_dly) m_axil_arready <= 1'b1; else ar_cnt <= ar_cnt + 1;
      end
    end
  end

  // Monitors: grant order per path, B count per master, leakage counters.
  int wlog[64], rlog[64];
  int wn = 0, rn = 0;
  int bcnt0 = 0, bcnt1 = 0, m1_touch = 0, cross_cnt = 0;
  always @(posedge clk) begin
    if (wn < 64) begin
      if (s_axil_awvalid[0] && s_axil_awready[0]) begin wlog[wn] <= 0; wn <= wn + 1; end
      else if (s_axil_awvalid[1] && s_axil_awready[1]) begin wlog[wn] <= 1; wn <= wn + 1; end
    end
    if (rn < 64) begin
      if (s_axil_arvalid[0] && s_axil_arready[0]) begin rlog[rn] <= 0; rn <= rn + 1; end
      else if (s_axil_arvalid[1] && s_axil_arready[1]) begin rlog[rn] <= 1; rn <= rn + 1; end
    end
    if (s_axil_bvalid[0] && s_axil_bready[0]) bcnt0 <= bcnt0 + 1;
    if (s_axil_bvalid[1] && s_axil_bready[1]) bcnt1 <= bcnt1 + 1;
    if (s_axil_awready[1] || s_axil_wready[1] || s_axil_bvalid[1] || s_axil_arready[1] || s_axil_rvalid[1])
      m1_touch <= m1_touch + 1;
    if (s_axil_bvalid[1] || s_axil_rvalid[0]) cross_cnt <= cross_cnt + 1;
  end

  // Reference model: expected memory contents and last-served master per path.
  logic [DW-1:0] exp_mem [logic [AW-1:0]];
  int model_last_w = 1, model_last_r = 1;

  function automatic int exp_first(input int last);
`ifdef AXIL_ARB_FIXED_PRIO_EN
    exp_first = (last < 0) ? 1 : 0;
`else
    exp_first = (last == 1) ? 0 : 1;
`endif
  endfunction

  task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    logic [DW-1:0] v;
    v = exp_mem.exists(a) ? exp_mem[a] : '0;
    for (int b = 0; b < SW; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    exp_mem[a] = v;
  endtask

  task automatic clear_drives();
    for (int i = 0; i < 2; i++) begin
      awaddr_d[i] = '0; araddr_d[i] = '0; wdata_d[i] = '0; wstrb_d[i] = '0;
      awvalid_d[i] = 1'b0; wvalid_d[i] = 1'b0; bready_d[i] = 1'b0;
      arvalid_d[i] = 1'b0; rready_d[i] = 1'b0;
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    clear_drives();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_last_w = 1; model_last_r = 1;
  endtask

  task automatic wr_start(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    awaddr_d[i] = a; wdata_d[i] = d; wstrb_d[i] = s;
    awvalid_d[i] = 1'b1; wvalid_d[i] = 1'b1; bready_d[i] = 1'b1;
  endtask

  task automatic wr_addr_phase(input int i);
    bit ap, wp, ahs, whs;
    int cyc;
    ap = 1; wp = 1; cyc = 0;
    while ((ap || wp) && cyc < 300) begin
      @(negedge clk);
      ahs = ap && s_axil_awready[i];
      whs = wp && s_axil_wready[i];
      @(posedge clk); #1;
      if (ahs) begin awvalid_d[i] = 1'b0; ap = 0; end
      if (whs) begin wvalid_d[i] = 1'b0; wp = 0; end
      cyc++;
    end
    total++;
    if ((ap || wp) !== 1'b0) fail("wr_addr_timeout", ap || wp, 1'b0);
  endtask

  task automatic wr_b_phase(input int i, output logic [1:0] resp);
    bit got;
    int cyc;
    got = 0; cyc = 0; resp = 2'bxx;
    while (!got && cyc < 300) begin
      @(negedge clk);
      if (s_axil_bvalid[i]) begin got = 1; resp = s_axil_bresp[2*i +: 2]; end
      @(posedge clk); #1;
      cyc++;
    end
    bready_d[i] = 1'b0;
    total++;
    if (got !== 1'b1) fail("wr_b_timeout", got, 1'b1);
  endtask

  task automatic wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    logic [1:0] resp;
    wr_start(i, a, d, s);
    wr_addr_phase(i);
    wr_b_phase(i, resp);
    total++;
    if (resp !== 2'b00) fail("wr_bresp", resp, 2'b00);
    model_write(a, d, s);
    model_last_w = i;
  endtask

  task automatic rd(input int i, input logic [AW-1:0] a, output logic [DW-1:0] d);
    bit got;
    int cyc;
    araddr_d[i] = a; arvalid_d[i] = 1'b1; rready_d[i] = 1'b1;
    got = 0; cyc = 0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      got = s_axil_arready[i];
      @(posedge clk); #1;
      cyc++;
    end
    arvalid_d[i] = 1'b0;
    total++;
    if (got !== 1'b1) fail("rd_ar_timeout", got, 1'b1);
    got = 0; cyc = 0; d = '0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      if (s_axil_rvalid[i]) begin got = 1; d = s_axil_rdata[DW*i +: DW]; end
      @(posedge clk); #1;
      cyc++;
    end
    rready_d[i] = 1'b0;
    total++;
    if (got !== 1'b1) fail("rd_r_timeout", got, 1'b1);
    model_last_r = i;
  endtask

  task automatic rd_chk(input int i, input logic [AW-1:0] a, input string tag);
    logic [DW-1:0] d;
    rd(i, a, d);
    total++;
    if (d !== exp_mem[a]) fail(tag, d, exp_mem[a]);
  endtask

  task automatic rand_delays();
    aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int ws, rs, b0, x0, m1b, f, seen, c;
    logic [DW-1:0] d;

    // Reset state.
    reset_dut();
    @(negedge clk);
    total++;
    if (ctl_vec !== 15'h0) fail("reset_ctl", ctl_vec, 15'h0);
    @(posedge clk); #1;

    // Single write from master 0, latency and payload muxing.
    aw_dly = 0; w_dly = 0;
    m1b = m1_touch; b0 = bcnt0;
    wr_start(0, 16'h0010, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    total++;
    if (m_axil_awvalid !== 1'b0) fail("aw_lat_n", m_axil_awvalid, 1'b0);
    @(negedge clk);
    total++;
    if (m_axil_awvalid !== 1'b1) fail("aw_lat_n1", m_axil_awvalid, 1'b1);
    total++;
    if (m_axil_awaddr !== 16'h0010) fail("awaddr_mux", m_axil_awaddr, 16'h0010);
    total++;
    if (m_axil_awprot !== 3'b001) fail("awprot_mux", m_axil_awprot, 3'b001);
    total++;
    if (m_axil_wdata !== 32'hDEADBEEF) fail("wdata_mux", m_axil_wdata, 32'hDEADBEEF);
    wr_addr_phase(0);
    begin
      logic [1:0] resp;
      wr_b_phase(0, resp);
      total++;
      if (resp !== 2'b00) fail("single_bresp", resp, 2'b00);
    end
    model_write(16'h0010, 32'hDEADBEEF, 4'hF);
    model_last_w = 0;
    total++;
    if ((bcnt0 - b0) !== 1) fail("single_b_count", bcnt0 - b0, 1);
    total++;
    if ((m1_touch - m1b) !== 0) fail("m1_quiet", m1_touch - m1b, 0);
    rd_chk(1, 16'h0010, "single_readback");

    // Simultaneous writes from a fresh reset, plus a partial-strobe overwrite.
    reset_dut();
    rand_delays();
    ws = wn;
    f = exp_first(model_last_w);
    fork
      wr(0, 16'h0020, 32'h11111111, 4'hF);
      wr(1, 16'h0024, 32'h22222222, 4'hF);
    join
    total++;
    if (wlog[ws] !== f) fail("sim_wr_first", wlog[ws], f);
    total++;
    if (wlog[ws+1] !== (1 - f)) fail("sim_wr_second", wlog[ws+1], 1 - f);
    rd_chk(0, 16'h0024, "sim_rd_0x24");
    rd_chk(1, 16'h0020, "sim_rd_0x20");
    wr(1, 16'h0020, $urandom, 4'($urandom_range(1, 15)));
    rd_chk(0, 16'h0020, "strb_merge");

    // Continuous read contention, 8 reads per master.
    for (int k = 0; k < 8; k++) begin
      rand_delays();
      wr(0, 16'h0100 + 16'(4*k), $urandom, 4'hF);
      wr(1, 16'h0200 + 16'(4*k), $urandom, 4'hF);
    end
    rand_delays();
    rs = rn;
    f = exp_first(model_last_r);
    fork
      for (int k = 0; k < 8; k++) rd_chk(0, 16'h0100 + 16'(4*k), "cont_rd_m0");
      for (int k = 0; k < 8; k++) rd_chk(1, 16'h0200 + 16'(4*k), "cont_rd_m1");
    join
    for (int k = 0; k < 16; k++) begin
      int e;
`ifdef AXIL_ARB_FIXED_PRIO_EN
      e = (k < 8) ? 0 : 1;
`else
      e = f ^ (k % 2);
`endif
      total++;
      if (rlog[rs+k] !== e) fail("cont_order", rlog[rs+k], e);
    end

    // Slave accepts AW well before W.
    aw_dly = 0; w_dly = 3; ar_dly = 0;
    b0 = bcnt0;
    fork
      wr(0, 16'h0050, $urandom, 4'hF);
      begin
        seen = 0; c = 0;
        while (!seen && c < 100) begin
          @(negedge clk);
          if (m_axil_awvalid && m_axil_awready) seen = 1;
          c++;
        end
        total++;
        if (seen !== 1) fail("split_aw_seen", seen, 1);
        @(negedge clk);
        total++;
        if (m_axil_awvalid !== 1'b0) fail("split_awvalid_drop", m_axil_awvalid, 1'b0);
        total++;
        if (m_axil_wvalid !== 1'b1) fail("split_wvalid_hold", m_axil_wvalid, 1'b1);
      end
    join
    repeat (5) @(negedge clk);
    total++;
    if ((bcnt0 - b0) !== 1) fail("split_one_b", bcnt0 - b0, 1);
    @(posedge clk); #1;
    rd_chk(1, 16'h0050, "split_readback");

    // Concurrent write (m0) and read (m1) with no cross-talk.
    rand_delays();
    wr(1, 16'h0040, $urandom, 4'hF);
    x0 = cross_cnt;
    fork
      wr(0, 16'h0030, $urandom, 4'hF);
      rd_chk(1, 16'h0040, "conc_rd_0x40");
    join
    total++;
    if ((cross_cnt - x0) !== 0) fail("conc_no_crosstalk", cross_cnt - x0, 0);
    rd_chk(1, 16'h0030, "conc_rd_0x30");

    // Reset while the write path waits in the response phase.
    aw_dly = 0; w_dly = 0; ar_dly = 0;
    wr_start(0, 16'h0060, $urandom, 4'hF);
    bready_d[0] = 1'b0;
    wr_addr_phase(0);
    seen = 0; c = 0;
    while (!seen && c < 20) begin
      @(negedge clk);
      if (s_axil_bvalid[0]) seen = 1;
      c++;
    end
    total++;
    if (seen !== 1) fail("wresp_pending", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (ctl_vec !== 15'h0) fail("async_rst_ctl", ctl_vec, 15'h0);
    clear_drives();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_last_w = 1; model_last_r = 1;
    ws = wn;
    wr(1, 16'h0064, $urandom, 4'hF);
    total++;
    if (wlog[ws] !== 1) fail("post_rst_grant_m1", wlog[ws], 1);
    rd_chk(0, 16'h0064, "post_rst_readback");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
